// File: rtl/ysyx_25040101_mdu_if.sv
// Request/response handshake bundle between the execute stage and the MDU.
interface ysyx_25040101_mdu_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] srca_data_i;
  logic [XLEN-1:0] srcb_data_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, srca_data_i, srcb_data_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, srca_data_i, srcb_data_i, flush_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/ysyx_25040101_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one iteration per cycle, sign fixed up when the result is registered.
module ysyx_25040101_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic                clock,
  input logic                reset,
  ysyx_25040101_mdu_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;

  logic              w_a_sgn, w_b_sgn, w_sa, w_sb;
  logic              w_is_div, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special_res;
  logic [XLEN:0]     w_msum, w_dtrial;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  // operand signedness per opcode
  always_comb begin
    case (bus.funct3_i)
      3'b001, 3'b100, 3'b110: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b010:                 begin w_a_sgn = 1'b1; w_b_sgn = 1'b0; end
      default:                begin w_a_sgn = 1'b0; w_b_sgn = 1'b0; end
    endcase
  end

  assign w_sa      = w_a_sgn & bus.srca_data_i[XLEN-1];
  assign w_sb      = w_b_sgn & bus.srcb_data_i[XLEN-1];
  assign w_abs_a   = w_sa ? -bus.srca_data_i : bus.srca_data_i;
  assign w_abs_b   = w_sb ? -bus.srcb_data_i : bus.srcb_data_i;
  assign w_is_div  = bus.funct3_i[2];
  assign w_div0    = w_is_div & (bus.srcb_data_i == {XLEN{1'b0}});
  assign w_ovf     = w_is_div & ~bus.funct3_i[0] & (bus.srca_data_i == INT_MIN)
                     & (bus.srcb_data_i == {XLEN{1'b1}});
  assign w_special = w_div0 | w_ovf;

  // results that skip the iteration loop; funct3[1] selects remainder
  always_comb begin
    if (w_div0) begin
      w_special_res = bus.funct3_i[1] ? bus.srca_data_i : {XLEN{1'b1}};
    end else if (w_ovf) begin
      w_special_res = bus.funct3_i[1] ? {XLEN{1'b0}} : INT_MIN;
    end else begin
      w_special_res = {XLEN{1'b0}};
    end
  end

  // one iteration: r_acc is {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_dtrial  = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    if (r_funct3[2]) begin
      if (!w_dtrial[XLEN]) begin
        w_acc_nxt = {w_dtrial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  // final result selection from the last iteration's value
  always_comb begin
    case (r_funct3)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      3'b110, 3'b111:         w_final = w_rem;
      default:                w_final = {XLEN{1'b0}};
    endcase
  end

  // next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = bus.valid_i ? (w_special ? S_DONE : S_BUSY) : S_IDLE;
        S_BUSY:  w_state_nxt = (r_cnt == LAST_CNT) ? S_DONE : S_BUSY;
        S_DONE:  w_state_nxt = bus.ready_i ? S_IDLE : S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // datapath: latch operands on accept, iterate in BUSY, hold result in DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_funct3 <= 3'b000;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= {XLEN{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_result <= {XLEN{1'b0}};
    end else if (bus.flush_i) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            r_funct3 <= bus.funct3_i;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_cnt    <= {CNT_W{1'b0}};
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_result <= w_special ? w_special_res : {XLEN{1'b0}};
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_result <= w_final;
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            r_result <= {XLEN{1'b0}};
          end
        end
        default: r_result <= {XLEN{1'b0}};
      endcase
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_ysyx_25040101_mdu.sv
// Self-checking bench for ysyx_25040101_mdu: directed vector table, random ops against
// an arithmetic reference model, and flush/reset sequences.
module tb_ysyx_25040101_mdu;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ysyx_25040101_mdu_if #(.XLEN(32)) bus();

  ysyx_25040101_mdu #(.XLEN(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb, lbu;
    logic [63:0] p;
    sa = a; sb = b; la = sa; lb = sb; lbu = {32'd0, b};
    case (f3)
      3'b000: begin p = la * lb; return p[31:0]; end
      3'b001: begin p = la * lb; return p[63:32]; end
      3'b010: begin p = la * lbu; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // issue one op, measure edges from accept to valid_o, hold off ready_i for 'hold' cycles
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int hold);
    int n;
    int lat;
    @(negedge clock);
    bus.valid_i = 1'b1; bus.funct3_i = f3; bus.srca_data_i = a; bus.srcb_data_i = b; bus.ready_i = 1'b0;
    n = 0;
    while (!bus.ready_o && n < 200) begin @(negedge clock); n++; end
    chk({nm, "_accept_ready"}, 32'(bus.ready_o), 32'd1);
    @(negedge clock);
    bus.valid_i = 1'b0;
    bus.srca_data_i = $urandom; bus.srcb_data_i = $urandom; bus.funct3_i = 3'($urandom_range(0, 7));
    lat = 1;
    while (!bus.valid_o && lat < 100) begin @(negedge clock); lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_result"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_valid"}, 32'(bus.valid_o), 32'd1);
      chk({nm, "_hold_result"}, bus.result_o, exp);
      chk({nm, "_hold_ready"}, 32'(bus.ready_o), 32'd0);
      @(negedge clock);
    end
    bus.ready_i = 1'b1;
    @(negedge clock);
    bus.ready_i = 1'b0;
    chk({nm, "_idle_ready"}, 32'(bus.ready_o), 32'd1);
    chk({nm, "_idle_valid"}, 32'(bus.valid_o), 32'd0);
    chk({nm, "_idle_result"}, bus.result_o, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] corner[6];
    checks = 0; errors = 0;
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};

    tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 0};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33, 0};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33, 0};
    tbl[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0};
    tbl[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1,  0};
    tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0};
    tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0};
    tbl[12] = '{3'b000, 32'd3,         32'd4,         32'd12,        33, 10};

    reset = 1'b1;
    bus.valid_i = 1'b0; bus.funct3_i = 3'b000; bus.srca_data_i = 32'd0; bus.srcb_data_i = 32'd0;
    bus.flush_i = 1'b0; bus.ready_i = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.ready_o), 32'd1);
    chk("reset_valid", 32'(bus.valid_o), 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].hold);
    end

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if (f3[2] && $urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
      do_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_mdu(f3, a, b), ref_lat(f3, a, b),
            $urandom_range(0, 3));
    end

    // flush at counter 10 of a DIVU; valid_i offered during the flush cycle is ignored
    @(negedge clock);
    bus.valid_i = 1'b1; bus.funct3_i = 3'b101; bus.srca_data_i = 32'd1000; bus.srcb_data_i = 32'd7;
    @(negedge clock);
    bus.valid_i = 1'b0;
    chk("flush_busy_ready", 32'(bus.ready_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("flush_no_valid", 32'(bus.valid_o), 32'd0);
      @(negedge clock);
    end
    bus.flush_i = 1'b1; bus.valid_i = 1'b1;
    @(negedge clock);
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    chk("flush_ready", 32'(bus.ready_o), 32'd1);
    chk("flush_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_result", bus.result_o, 32'd0);
    do_op("after_flush_divu", 3'b101, 32'd9, 32'd3, 32'd3, 33, 0);

    // flush in IDLE with a request present: nothing accepted
    @(negedge clock);
    bus.flush_i = 1'b1; bus.valid_i = 1'b1; bus.funct3_i = 3'b000;
    @(negedge clock);
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    chk("flush_idle_ready", 32'(bus.ready_o), 32'd1);

    // flush while holding a special-case result in DONE
    @(negedge clock);
    bus.valid_i = 1'b1; bus.funct3_i = 3'b111; bus.srca_data_i = 32'd5; bus.srcb_data_i = 32'd0;
    @(negedge clock);
    bus.valid_i = 1'b0;
    chk("flush_done_pre_valid", 32'(bus.valid_o), 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clock);
    bus.flush_i = 1'b0;
    chk("flush_done_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_done_result", bus.result_o, 32'd0);
    chk("flush_done_ready", 32'(bus.ready_o), 32'd1);

    // asynchronous reset mid-BUSY, checked between clock edges
    @(negedge clock);
    bus.valid_i = 1'b1; bus.funct3_i = 3'b000; bus.srca_data_i = 32'd6; bus.srcb_data_i = 32'd7;
    @(negedge clock);
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clock);
    chk("areset_pre_ready", 32'(bus.ready_o), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("areset_ready", 32'(bus.ready_o), 32'd1);
    chk("areset_valid", 32'(bus.valid_o), 32'd0);
    chk("areset_result", bus.result_o, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op("after_reset_mul", 3'b000, 32'd6, 32'd7, 32'd42, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
